ram_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single-port 32-bit synchronous RAM macro: it shares one RAM port between an instruction-fetch port (read-only) and a data port (byte-write capable). It sits between the core's fetch/load-store units and the RAM. It grants at most one access per cycle using round-robin arbitration and routes the one-cycle-latency read data back to the winning requester.

---
 rtl/ram_arbiter_pkg.sv | 14 +
 rtl/rr_arb2.sv | 28 ++
 rtl/ram_arbiter.sv | 69 ++++++
 tb/tb_ram_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: port encodings and address-width derivation shared by the
// RAM arbiter and its round-robin sub-block.
package ram_arbiter_pkg;

    typedef logic port_t;

    localparam port_t PORT_I = 1'b0;
    localparam port_t PORT_D = 1'b1;

    function automatic int a_width(input int cols);
        return 8 + $clog2(cols);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter; bit 0 is the fetch port, bit 1 the
// data port. Grants are combinational and forced low while reset is asserted.
module rr_arb2
    import ram_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    port_t last_winner;

    // on conflict the port that did not win last time goes first
    always_comb begin
        gnt = 2'b00;
        if (rst_n)
            gnt = (req == 2'b11) ? ((last_winner == PORT_D) ? 2'b01 : 2'b10) : req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last_winner <= PORT_D;
        else if (|gnt)
            last_winner <= gnt[1] ? PORT_D : PORT_I;
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port synchronous RAM between a read-only fetch
// port and a byte-writable data port, routing one-cycle-latency responses back.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter  int COLS    = 4,
    localparam int A_WIDTH = a_width(COLS)
) (
    input  logic               CLK,
    input  logic               RESETn,
    input  logic               i_req,
    input  logic [A_WIDTH-1:0] i_addr,
    output logic               i_gnt,
    output logic               i_rvalid,
    output logic [31:0]        i_rdata,
    input  logic               d_req,
    input  logic [3:0]         d_we,
    input  logic [A_WIDTH-1:0] d_addr,
    input  logic [31:0]        d_wdata,
    output logic               d_gnt,
    output logic               d_rvalid,
    output logic [31:0]        d_rdata,
    output logic               ram_en,
    output logic [3:0]         ram_we,
    output logic [A_WIDTH-1:0] ram_a,
    output logic [31:0]        ram_di,
    input  logic [31:0]        ram_do
);

    logic [1:0] gnt;
    logic       resp_valid;
    port_t      resp_port;

    rr_arb2 u_arb (
        .clk   (CLK),
        .rst_n (RESETn),
        .req   ({d_req, i_req}),
        .gnt   (gnt)
    );

    assign i_gnt = gnt[0];
    assign d_gnt = gnt[1];

    always_comb begin
        ram_en = i_gnt | d_gnt;
        ram_we = d_gnt ? d_we : 4'b0000;
        ram_a  = i_gnt ? i_addr : (d_gnt ? d_addr : '0);
        ram_di = ram_en ? d_wdata : 32'h0;
    end

    // async reset drops any response still in flight
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            resp_valid <= 1'b0;
            resp_port  <= PORT_I;
        end else begin
            resp_valid <= ram_en;
            resp_port  <= d_gnt ? PORT_D : PORT_I;
        end
    end

    always_comb begin
        i_rvalid = resp_valid && (resp_port == PORT_I);
        d_rvalid = resp_valid && (resp_port == PORT_D);
        i_rdata  = i_rvalid ? ram_do : 32'h0;
        d_rdata  = d_rvalid ? ram_do : 32'h0;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: table vectors, directed corner sequences and random traffic
// checked against a transaction-level model of arbitration and memory contents.
module tb_ram_arbiter;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0;
    logic [9:0]  i_addr = '0, d_addr = '0;
    logic [3:0]  d_we = '0;
    logic [31:0] d_wdata = '0;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, ram_en;
    logic [31:0] i_rdata, d_rdata, ram_di;
    logic [31:0] ram_do = '0;
    logic [3:0]  ram_we;
    logic [9:0]  ram_a;

    ram_arbiter #(.COLS(4)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di), .ram_do(ram_do)
    );

    always #5 CLK = ~CLK;

    // behavioural RAM macro: read-before-write, output 0 when not enabled
    logic [31:0] ram [1024];
    always @(posedge CLK) begin
        ram_do <= ram_en ? ram[ram_a] : 32'h0;
        if (ram_en)
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) ram[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
    end

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [31:0] ref_mem [1024];
    int          m_last;
    bit          pend_v;
    int          pend_p;
    logic [31:0] pend_d;

    logic        s_i_gnt, s_d_gnt, s_i_rvalid, s_d_rvalid;
    logic [31:0] s_i_rdata, s_d_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic ir, input logic [9:0] ia, input logic dr,
                       input logic [3:0] dw, input logic [9:0] da, input logic [31:0] dd,
                       input logic rn);
        int w;
        logic [9:0] a;
        @(negedge CLK);
        RESETn = rn; i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        #1;
        if (!rn) begin
            m_last = 1;
            pend_v = 0;
        end
        w = -1;
        if (rn) begin
            if (ir && dr) w = (m_last == 1) ? 0 : 1;
            else if (ir) w = 0;
            else if (dr) w = 1;
        end
        a = (w == 1) ? da : ((w == 0) ? ia : 10'h0);
        chk("i_gnt", 32'(i_gnt), 32'(w == 0));
        chk("d_gnt", 32'(d_gnt), 32'(w == 1));
        chk("ram_en", 32'(ram_en), 32'(w >= 0));
        chk("ram_we", 32'(ram_we), (w == 1) ? 32'(dw) : 32'h0);
        chk("ram_a", 32'(ram_a), 32'(a));
        chk("ram_di", ram_di, (w >= 0) ? dd : 32'h0);
        chk("i_rvalid", 32'(i_rvalid), 32'(pend_v && pend_p == 0));
        chk("d_rvalid", 32'(d_rvalid), 32'(pend_v && pend_p == 1));
        chk("i_rdata", i_rdata, (pend_v && pend_p == 0) ? pend_d : 32'h0);
        chk("d_rdata", d_rdata, (pend_v && pend_p == 1) ? pend_d : 32'h0);
        s_i_gnt = i_gnt; s_d_gnt = d_gnt; s_i_rvalid = i_rvalid; s_d_rvalid = d_rvalid;
        s_i_rdata = i_rdata; s_d_rdata = d_rdata;
        pend_v = (w >= 0);
        if (w >= 0) begin
            m_last = w;
            pend_p = w;
            pend_d = ref_mem[a];
            if (w == 1)
                for (int b = 0; b < 4; b++)
                    if (dw[b]) ref_mem[a][8*b +: 8] = dd[8*b +: 8];
        end
    endtask

    task automatic idle();
        cyc(0, 10'h0, 0, 4'h0, 10'h0, 32'h0, 1);
    endtask

    typedef struct {
        logic rn, ir, dr, eig, edg;
    } vec_t;

    vec_t vecs [12];

    initial begin
        logic        hi, hd, ir, dr;
        logic [9:0]  ia, da;
        logic [3:0]  dw;
        logic [31:0] dd;
        for (int k = 0; k < 1024; k++) begin
            ram[k] = 32'(k) * 32'h9E3779B9;
            ref_mem[k] = 32'(k) * 32'h9E3779B9;
        end
        m_last = 1; pend_v = 0; pend_p = 0; pend_d = '0;

        vecs = '{
            '{0, 1, 1, 0, 0}, '{0, 1, 1, 0, 0}, '{1, 1, 1, 1, 0}, '{1, 1, 1, 0, 1},
            '{1, 1, 0, 1, 0}, '{1, 1, 1, 0, 1}, '{1, 0, 1, 0, 1}, '{1, 1, 1, 1, 0},
            '{1, 0, 0, 0, 0}, '{1, 1, 1, 0, 1}, '{1, 0, 1, 0, 1}, '{1, 1, 0, 1, 0}
        };
        foreach (vecs[n]) begin
            cyc(vecs[n].ir, 10'(n), vecs[n].dr, 4'h0, 10'(100 + n), 32'h0, vecs[n].rn);
            chk("tbl_i_gnt", 32'(s_i_gnt), 32'(vecs[n].eig));
            chk("tbl_d_gnt", 32'(s_d_gnt), 32'(vecs[n].edg));
            if (!vecs[n].rn) begin
                chk("rst_i_rvalid", 32'(s_i_rvalid), 32'h0);
                chk("rst_d_rdata", s_d_rdata, 32'h0);
            end
        end
        idle();

        ram[10'h010] = 32'hDEADBEEF; ref_mem[10'h010] = 32'hDEADBEEF;
        cyc(1, 10'h010, 0, 4'h0, 10'h0, 32'h0, 1);
        chk("fetch_gnt", 32'(s_i_gnt), 32'h1);
        idle();
        chk("fetch_rvalid", 32'(s_i_rvalid), 32'h1);
        chk("fetch_rdata", s_i_rdata, 32'hDEADBEEF);
        chk("fetch_d_rvalid", 32'(s_d_rvalid), 32'h0);

        ram[10'h020] = 32'h11223344; ref_mem[10'h020] = 32'h11223344;
        cyc(0, 10'h0, 1, 4'b0101, 10'h020, 32'hAABBCCDD, 1);
        cyc(0, 10'h0, 1, 4'b0000, 10'h020, 32'h0, 1);
        chk("bw_old_data", s_d_rdata, 32'h11223344);
        idle();
        chk("bw_read", s_d_rdata, 32'h11BB33DD);

        cyc(0, 10'h0, 1, 4'h0, 10'h005, 32'h0, 1);
        for (int n = 0; n < 6; n++) begin
            cyc(1, 10'(200 + n), 1, 4'h0, 10'(300 + n), 32'h0, 1);
            chk("cont_i_gnt", 32'(s_i_gnt), 32'(n % 2 == 0));
            chk("cont_d_gnt", 32'(s_d_gnt), 32'(n % 2 == 1));
            if (n > 0) chk("cont_rvalid", 32'(s_i_rvalid), 32'(n % 2 == 1));
        end
        idle();

        cyc(0, 10'h0, 1, 4'hF, 10'h0FF, 32'hCAFEF00D, 1);
        cyc(1, 10'h0FF, 0, 4'h0, 10'h0, 32'h0, 1);
        idle();
        chk("hazard_rdata", s_i_rdata, 32'hCAFEF00D);

        cyc(0, 10'h0, 1, 4'h0, 10'h030, 32'h0, 1);
        cyc(1, 10'h0, 1, 4'h0, 10'h030, 32'h0, 0);
        chk("midrst_d_rvalid", 32'(s_d_rvalid), 32'h0);
        chk("midrst_gnt", 32'({s_i_gnt, s_d_gnt}), 32'h0);
        cyc(1, 10'h0, 1, 4'h0, 10'h030, 32'h0, 1);
        chk("midrst_first_i", 32'(s_i_gnt), 32'h1);
        idle();

        hi = 0; hd = 0; ia = '0; da = '0; dw = '0; dd = '0;
        for (int n = 0; n < 600; n++) begin
            if (hi) ir = ($urandom_range(0, 7) != 0);
            else begin
                ir = $urandom_range(0, 1) == 1;
                ia = 10'($urandom_range(0, 1023));
            end
            if (hd) dr = ($urandom_range(0, 7) != 0);
            else begin
                dr = $urandom_range(0, 1) == 1;
                da = 10'($urandom_range(0, 15)) << $urandom_range(0, 6);
                dw = $urandom_range(0, 1) ? 4'($urandom_range(0, 15)) : 4'h0;
                dd = $urandom;
            end
            cyc(ir, ia, dr, dw, da, dd, $urandom_range(0, 63) != 0);
            hi = ir && !s_i_gnt && RESETn;
            hd = dr && !s_d_gnt && RESETn;
        end
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
